// File: rtl/jtbubl_linebuf.sv
// jtbubl_linebuf: double-buffered object line buffer with read-and-erase scan-out.
// The renderer fills bank sel while the video side reads and blanks bank ~sel.
module jtbubl_linebuf #(
    parameter int                 DW     = 8,
    parameter int                 AW     = 9,
    parameter logic [DW-1:0]      BLANK  = 8'hFF,
    parameter int                 ALPHAW = 4,
    parameter logic [ALPHAW-1:0]  ALPHA  = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LHBL,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] wr_addr,
    input  logic          we,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd,
    output logic [DW-1:0] rd_data,
    output logic          wr_bank
);
    logic [DW-1:0] mem [0:2**(AW+1)-1] = '{default: BLANK};
    logic          sel_q, sel_d, last_q, pend_q, pend_d, eb_q, eb_d;
    logic [AW-1:0] ea_q, ea_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          wr_en;
    assign wr_en   = we && wr_data[ALPHAW-1:0] != ALPHA;
    assign rd_data = rd_data_q;
    assign wr_bank = sel_q;
    // A pending erase owns the read port, so a colliding rd keeps the old pixel
    always_comb begin
        sel_d     = sel_q ^ (last_q & ~LHBL);
        pend_d    = rd;
        ea_d      = rd ? rd_addr : ea_q;
        eb_d      = rd ? ~sel_q : eb_q;
        rd_data_d = (rd && pend_q) ? rd_data_q : mem[{~sel_q, rd_addr}];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            pend_q    <= 1'b0;
            eb_q      <= 1'b0;
            ea_q      <= '0;
            rd_data_q <= BLANK;
        end else begin
            sel_q     <= sel_d;
            last_q    <= LHBL;
            pend_q    <= pend_d;
            eb_q      <= eb_d;
            ea_q      <= ea_d;
            rd_data_q <= rd_data_d;
        end
    end
    // Write comes after the erase so it wins on a same-location collision
    always_ff @(posedge clk) begin
        if (pend_q) mem[{eb_q, ea_q}] <= BLANK;
        if (wr_en) mem[{sel_q, wr_addr}] <= wr_data;
    end
endmodule

// File: tb/tb_jtbubl_linebuf.sv
// tb_jtbubl_linebuf: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_jtbubl_linebuf;
    logic       clk = 0, rst = 1, LHBL = 1, we = 0, rd = 0;
    logic [7:0] wr_data = 0, rd_data;
    logic [8:0] wr_addr = 0, rd_addr = 0;
    logic       wr_bank, rd_seen = 0;
    int         checks = 0, errors = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    jtbubl_linebuf dut (
        .clk(clk), .rst(rst), .LHBL(LHBL), .wr_data(wr_data), .wr_addr(wr_addr),
        .we(we), .rd_addr(rd_addr), .rd(rd), .rd_data(rd_data), .wr_bank(wr_bank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rd yields one rd_data word on the following edge
    always @(posedge clk) rd_seen <= rd && !rst;
    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) chk("unexpected_read", rd_data, 8'hxx);
            else chk(name_q.pop_front(), rd_data, exp_q.pop_front());
        end
    end

    task automatic tick; @(negedge clk); endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        we = 1; wr_addr = a; wr_data = d;
        tick();
        we = 0;
    endtask

    task automatic swap(input logic exp_bank);
        LHBL = 0;
        repeat (3) tick();
        LHBL = 1;
        tick();
        chk("wr_bank_after_swap", {7'd0, wr_bank}, {7'd0, exp_bank});
    endtask

    task automatic rd_px(input logic [8:0] a, input logic [7:0] e, input string n);
        exp_q.push_back(e); name_q.push_back(n);
        rd = 1; rd_addr = a;
        tick();
        rd = 0;
        tick();
    endtask

    task automatic rd_pair(input logic [8:0] a, input logic [7:0] e);
        exp_q.push_back(e); name_q.push_back("b2b_first");
        exp_q.push_back(e); name_q.push_back("b2b_hold");
        rd = 1; rd_addr = a;
        tick();
        rd_addr = a + 9'd1;
        tick();
        rd = 0;
        repeat (2) tick();
    endtask

    initial begin
        logic [8:0] a;
        repeat (2) tick();
        chk("reset_rd_data", rd_data, 8'hFF);
        chk("reset_wr_bank", {7'd0, wr_bank}, 8'h00);
        rst = 0;
        tick();
        wr(9'h020, 8'h35);
        wr(9'h050, 8'h12); wr(9'h050, 8'h3F);
        wr(9'h051, 8'h12); wr(9'h051, 8'h47);
        swap(1);
        rd_px(9'h020, 8'h35, "round_trip");
        rd_px(9'h020, 8'hFF, "erased_after_read");
        rd_px(9'h050, 8'h12, "transparent_dropped");
        rd_px(9'h051, 8'h47, "overwrite");
        swap(0);
        for (int i = 0; i < 8; i++) wr(9'(i), 8'hA0 + 8'(i));
        swap(1);
        wr(9'h000, 8'h55);
        for (int i = 0; i < 8; i++) rd_px(9'(i), 8'hA0 + 8'(i), "swap_isolation");
        swap(0);
        rd_px(9'h000, 8'h55, "next_line_bank1");
        a = 9'h1FF;
        wr(a, 8'h61);
        a = a + 9'd1;
        wr(a, 8'h62);
        swap(1);
        rd_px(9'h1FF, 8'h61, "wrap_top");
        rd_px(9'h000, 8'h62, "wrap_zero");
        wr(9'h010, 8'h22); wr(9'h011, 8'h22);
        wr(9'h013, 8'h44); wr(9'h014, 8'h66);
        swap(0);
        rd_pair(9'h010, 8'h22);
        rd_px(9'h010, 8'hFF, "b2b_erase_a");
        rd_px(9'h011, 8'hFF, "b2b_erase_b");
        rd_pair(9'h013, 8'h44);
        rd_px(9'h013, 8'hFF, "b2b_erase_c");
        rd_px(9'h014, 8'hFF, "b2b_erase_d");
        // Write in the swap cycle lands in the old bank, the next one in the new bank
        wr(9'h1A0, 8'h5A);
        LHBL = 0; we = 1; wr_addr = 9'h100; wr_data = 8'h71;
        tick();
        wr_addr = 9'h101; wr_data = 8'h72;
        tick();
        we = 0; LHBL = 1;
        tick();
        chk("swap_edge_bank", {7'd0, wr_bank}, 8'h01);
        swap(0);
        rd_px(9'h101, 8'h72, "write_after_swap_new_bank");
        rd_px(9'h100, 8'hFF, "swap_cycle_not_in_new_bank");
        swap(1);
        exp_q.push_back(8'h5A); name_q.push_back("pre_reset_read");
        rd = 1; rd_addr = 9'h1A0;
        tick();
        rd = 0;
        #2 rst = 1;
        #1;
        chk("midline_rst_wr_bank", {7'd0, wr_bank}, 8'h00);
        chk("midline_rst_rd_data", rd_data, 8'hFF);
        tick();
        rst = 0;
        tick();
        swap(1);
        rd_px(9'h1A0, 8'h5A, "pending_erase_discarded");
        repeat (3) tick();
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
